// File: rtl/jtag_ahb_pkg.sv
// Shared constants, FSM state type and command payload for the JTAG-to-AHB-Lite master.
package jtag_ahb_pkg;

    localparam int unsigned AHB_ADDR_W = 32;
    localparam int unsigned AHB_DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/jtag_ahb_cmd_fifo.sv
// Synchronous command queue; pointers carry an extra wrap bit to tell full from empty.
module jtag_ahb_cmd_fifo
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    cmd_t             r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[IDX_W-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/jtag_ahb_master.sv
// Sequences single AHB-Lite transfers for commands queued by the JTAG TAP.
// Optional wait-state timeout enabled by defining JTAG_AHB_TIMEOUT_EN.
module jtag_ahb_master
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    state_t r_state;
    cmd_t   w_cmd_in;
    cmd_t   w_head;
    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_timeout;

    assign w_cmd_in  = '{write: CMD_WRITE,
                         addr:  AHB_ADDR_W'(CMD_ADDR),
                         wdata: AHB_DATA_W'(CMD_WDATA)};
    assign CMD_READY = !w_full;
    assign w_push    = CMD_VALID && CMD_READY;
    assign w_pop     = ((r_state == ST_DATA) && HREADY) || w_timeout;
    assign HSIZE     = HSIZE_WORD;

    jtag_ahb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef JTAG_AHB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts consecutive stalled cycles; any state change or ready cycle restarts it.
    assign w_timeout = (r_state != ST_IDLE) && !HREADY &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_IDLE) || HREADY || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    // Without the timeout the limit has no effect; the bus is waited on indefinitely.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_ADDR;
                        HTRANS  <= HTRANS_NONSEQ;
                        HADDR   <= ADDR_WIDTH'(w_head.addr);
                        HWRITE  <= w_head.write;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_state <= ST_DATA;
                        HTRANS  <= HTRANS_IDLE;
                        HWDATA  <= DATA_WIDTH'(w_head.wdata);
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        HTRANS    <= HTRANS_IDLE;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    // An ERROR response first shows with HREADY low, so only the ready cycle completes.
                    if (HREADY) begin
                        r_state   <= ST_IDLE;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= HRESP;
                        if (!HWRITE) RSP_RDATA <= HRDATA;
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    HTRANS  <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_ahb_master.sv
// Directed and randomized checks of jtag_ahb_master against a transaction-level model.
module tb_jtag_ahb_master;

`ifdef JTAG_AHB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    jtag_ahb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cycle      = 0;
    int          rsp_cnt    = 0;
    logic [31:0] exp_rdata  = '0;
    logic [31:0] ns_addr [$];
    int          ns_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and log bus/response activity seen just after the edge.
    task automatic step();
        @(posedge HCLK);
        #1;
        cycle++;
        if (HTRANS === 2'b10) begin
            ns_addr.push_back(HADDR);
            ns_cyc.push_back(cycle);
        end
        if (RSP_VALID === 1'b1) rsp_cnt++;
    endtask

    task automatic wait_nonseq();
        int n = 0;
        while (HTRANS !== 2'b10 && n < 8) begin
            step();
            n++;
        end
        chk("nonseq_seen", 32'(HTRANS), 32'h2);
    endtask

    // One isolated transfer from an idle, empty master; expectations come from the protocol rules.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit err, input logic [31:0] bus);
        int c_acc;
        chk("cmd_ready_idle", 32'(CMD_READY), 32'h1);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
        HREADY = 1'b1; HRESP = 1'b0;
        step();
        c_acc = cycle;
        CMD_VALID = 1'b0;
        wait_nonseq();
        chk("haddr", HADDR, addr);
        chk("hwrite", 32'(HWRITE), 32'(wr));
        step();
        chk("htrans_data", 32'(HTRANS), 32'h0);
        if (wr) chk("hwdata", HWDATA, wdata);
        HRDATA = bus;
        if (err) begin
            HREADY = 1'b0; HRESP = 1'b1;
            step();
            chk("rsp_early_err", 32'(RSP_VALID), 32'h0);
        end else begin
            for (int i = 0; i < waits; i++) begin
                HREADY = 1'b0;
                step();
                chk("rsp_early_wait", 32'(RSP_VALID), 32'h0);
            end
        end
        HREADY = 1'b1;
        step();
        if (!wr) exp_rdata = bus;
        chk("rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("rsp_latency", 32'(cycle - c_acc), 32'(3 + (err ? 1 : waits)));
        chk("rsp_err", 32'(RSP_ERR), 32'(err));
        chk("rsp_rdata", RSP_RDATA, exp_rdata);
        HRESP = 1'b0;
        step();
        chk("rsp_pulse", 32'(RSP_VALID), 32'h0);
    endtask

    initial begin
        logic [31:0] rv;
        HRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_cmd_ready", 32'(CMD_READY), 32'h1);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
        chk("rst_rsp_err", 32'(RSP_ERR), 32'h0);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h2);
        HRESET = 1'b0;
        step();

        // Zero-wait write, then a read with two data-phase wait states.
        do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'hA5A5_0001);
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, 32'h1234_5678);

        // Two queued writes fill the queue; a third waits for space and order is kept.
        ns_addr.delete(); ns_cyc.delete(); rsp_cnt = 0;
        HREADY = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h100; CMD_WDATA = 32'h1;
        step();
        CMD_ADDR = 32'h104; CMD_WDATA = 32'h2;
        step();
        chk("full_ready_low", 32'(CMD_READY), 32'h0);
        CMD_ADDR = 32'h108; CMD_WDATA = 32'h3;
        begin
            int n = 0;
            while (CMD_READY !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            chk("third_accepted", 32'(CMD_READY), 32'h1);
        end
        step();
        CMD_VALID = 1'b0;
        repeat (12) step();
        chk("b2b_nonseq_count", 32'(ns_addr.size()), 32'h3);
        chk("b2b_rsp_count", 32'(rsp_cnt), 32'h3);
        if (ns_addr.size() == 3) begin
            chk("b2b_order0", ns_addr[0], 32'h100);
            chk("b2b_order1", ns_addr[1], 32'h104);
            chk("b2b_order2", ns_addr[2], 32'h108);
            chk("b2b_gap0", 32'(ns_cyc[1] - ns_cyc[0]), 32'h3);
            chk("b2b_gap1", 32'(ns_cyc[2] - ns_cyc[1]), 32'h3);
        end

        // Two-cycle ERROR on a write, followed by a queued read that completes cleanly.
        rv = $urandom;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_FFF0; CMD_WDATA = 32'h5555_AAAA;
        step();
        CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0044;
        step();
        CMD_VALID = 1'b0;
        chk("err_nonseq", 32'(HTRANS), 32'h2);
        chk("err_haddr", HADDR, 32'hFFFF_FFF0);
        step();
        HREADY = 1'b0; HRESP = 1'b1;
        step();
        chk("err_first_cycle", 32'(RSP_VALID), 32'h0);
        HREADY = 1'b1;
        step();
        chk("err_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("err_rsp_err", 32'(RSP_ERR), 32'h1);
        HRESP = 1'b0;
        step();
        chk("err_single_pulse", 32'(RSP_VALID), 32'h0);
        chk("err_next_nonseq", 32'(HTRANS), 32'h2);
        chk("err_next_haddr", HADDR, 32'h0000_0044);
        HRDATA = rv;
        step();
        step();
        exp_rdata = rv;
        chk("err_next_valid", 32'(RSP_VALID), 32'h1);
        chk("err_next_err", 32'(RSP_ERR), 32'h0);
        chk("err_next_rdata", RSP_RDATA, exp_rdata);
        step();

        // Reset during a stalled data phase abandons both queued commands silently.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h200; CMD_WDATA = 32'h7;
        step();
        CMD_ADDR = 32'h204;
        step();
        CMD_VALID = 1'b0;
        step();
        HREADY = 1'b0;
        step();
        HRESET = 1'b1;
        #1;
        chk("rstmid_htrans", 32'(HTRANS), 32'h0);
        chk("rstmid_ready", 32'(CMD_READY), 32'h1);
        step();
        HRESET = 1'b0;
        HREADY = 1'b1;
        exp_rdata = '0;
        rsp_cnt = 0;
        ns_addr.delete(); ns_cyc.delete();
        repeat (6) step();
        chk("rstmid_no_rsp", 32'(rsp_cnt), 32'h0);
        chk("rstmid_no_xfer", 32'(ns_addr.size()), 32'h0);
        chk("rstmid_rdata", RSP_RDATA, 32'h0);
        do_xfer(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 0, 1'b0, 32'h0);

        // Randomized isolated transfers.
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                    int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), $urandom);
        end

`ifdef JTAG_AHB_TIMEOUT_EN
        // Data phase held off until the wait-state limit forces an error response.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h400;
        step();
        CMD_VALID = 1'b0;
        wait_nonseq();
        step();
        HREADY = 1'b0;
        begin
            int n = 0;
            while (RSP_VALID !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("tmo_wait_cycles", 32'(n), 32'(TMO));
        end
        chk("tmo_rsp_err", 32'(RSP_ERR), 32'h1);
        chk("tmo_rdata_kept", RSP_RDATA, exp_rdata);
        HREADY = 1'b1;
        step();
        chk("tmo_idle", 32'(HTRANS), 32'h0);
        chk("tmo_ready", 32'(CMD_READY), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
